// File: rtl/fetch_ifid.sv
// Instruction fetch stage and IF/ID pipeline register: PC, I-cache request, stall/flush/HALT handling.
// Optional FETCH_STATS_EN macro adds fetch_count/stall_count performance counters.
module fetch_ifid #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000,
   parameter logic [5:0]  HALT_OP = 6'h3F
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic [31:0] imemload,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   input  logic        stall_IFID,
   input  logic        flush_IFID,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instr_out,
   output logic [31:0] npc_out,
   output logic        valid_out,
`ifdef FETCH_STATS_EN
   output logic        halted,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count
`else
   output logic        halted
`endif
);

   typedef enum logic {RUN, HALT} state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n, pc_inc;
   logic [31:0] instr_n, npc_n;
   logic        valid_n;

   assign pc_inc   = pc + 32'd4;
   assign imemaddr = pc;
   assign imemREN  = (state == RUN);
   assign halted   = (state == HALT);

   always_comb begin
      state_n = state;
      pc_n    = pc;
      instr_n = instr_out;
      npc_n   = npc_out;
      valid_n = valid_out;
      if (flush_IFID) begin
         // Redirect abandons any outstanding miss; npc_out is left as-is.
         state_n = RUN;
         pc_n    = redirect_pc;
         instr_n = 32'd0;
         valid_n = 1'b0;
      end else if (stall_IFID) begin
         // hold everything
      end else if (state == RUN) begin
         if (ihit) begin
            instr_n = imemload;
            npc_n   = pc_inc;
            valid_n = 1'b1;
            // HALT word goes to decode, but the PC parks on it.
            if (imemload[31:26] == HALT_OP) state_n = HALT;
            else                            pc_n    = pc_inc;
         end else begin
            instr_n = 32'd0;
            valid_n = 1'b0;
         end
      end else begin
         instr_n = 32'd0;
         valid_n = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= RUN;
         pc        <= PC_INIT;
         instr_out <= 32'd0;
         npc_out   <= 32'd0;
         valid_out <= 1'b0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         instr_out <= instr_n;
         npc_out   <= npc_n;
         valid_out <= valid_n;
      end
   end

`ifdef FETCH_STATS_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         fetch_count <= 32'd0;
         stall_count <= 32'd0;
      end else begin
         if (valid_n && !flush_IFID && !stall_IFID && state == RUN)
            fetch_count <= fetch_count + 32'd1;
         if (state == RUN && !flush_IFID && (stall_IFID || !ihit))
            stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ifid.sv
// Directed table-driven bench for fetch_ifid plus hand sequences for sequential fetch and counters.
module tb_fetch_ifid;

   logic        CLK = 1'b0;
   logic        RST, ihit, stall_IFID, flush_IFID;
   logic [31:0] imemload, redirect_pc;
   logic        imemREN, valid_out, halted;
   logic [31:0] imemaddr, instr_out, npc_out;
`ifdef FETCH_STATS_EN
   logic [31:0] fetch_count, stall_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   fetch_ifid dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
      .imemREN(imemREN), .imemaddr(imemaddr),
      .stall_IFID(stall_IFID), .flush_IFID(flush_IFID), .redirect_pc(redirect_pc),
      .instr_out(instr_out), .npc_out(npc_out), .valid_out(valid_out),
`ifdef FETCH_STATS_EN
      .halted(halted), .fetch_count(fetch_count), .stall_count(stall_count)
`else
      .halted(halted)
`endif
   );

   typedef struct {
      logic        rst, ihit;
      logic [31:0] load;
      logic        stall, flush;
      logic [31:0] rpc;
      logic [31:0] e_addr;
      logic        e_ren;
      logic [31:0] e_instr, e_npc;
      logic        e_valid, e_halt;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic hit, input logic [31:0] load,
                        input logic stall, input logic flush, input logic [31:0] rpc);
      @(negedge CLK);
      RST = rst; ihit = hit; imemload = load;
      stall_IFID = stall; flush_IFID = flush; redirect_pc = rpc;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; ihit = 1'b0; imemload = 32'd0;
      stall_IFID = 1'b0; flush_IFID = 1'b0; redirect_pc = 32'd0;

      //           rst  hit  load           stl  fl   rpc            addr           ren  instr          npc            v    h
      vecs.push_back('{1'b1,1'b0,32'h0,         1'b0,1'b0,32'h0,         32'h0,         1'b1,32'h0,         32'h0,         1'b0,1'b0});
      vecs.push_back('{1'b0,1'b1,32'h2008_0001, 1'b0,1'b0,32'h0,         32'h4,         1'b1,32'h2008_0001, 32'h4,         1'b1,1'b0});
      vecs.push_back('{1'b0,1'b0,32'h0,         1'b0,1'b0,32'h0,         32'h4,         1'b1,32'h0,         32'h4,         1'b0,1'b0});
      vecs.push_back('{1'b0,1'b0,32'h0,         1'b0,1'b0,32'h0,         32'h4,         1'b1,32'h0,         32'h4,         1'b0,1'b0});
      vecs.push_back('{1'b0,1'b1,32'h1234_5678, 1'b1,1'b0,32'h0,         32'h4,         1'b1,32'h0,         32'h4,         1'b0,1'b0});
      vecs.push_back('{1'b0,1'b1,32'h0000_0020, 1'b0,1'b0,32'h0,         32'h8,         1'b1,32'h0000_0020, 32'h8,         1'b1,1'b0});
      vecs.push_back('{1'b0,1'b1,32'hAAAA_AAAA, 1'b1,1'b0,32'h0,         32'h8,         1'b1,32'h0000_0020, 32'h8,         1'b1,1'b0});
      vecs.push_back('{1'b0,1'b1,32'h1111_1111, 1'b1,1'b1,32'h100,       32'h100,       1'b1,32'h0,         32'h8,         1'b0,1'b0});
      vecs.push_back('{1'b0,1'b1,32'h8C01_0004, 1'b0,1'b0,32'h0,         32'h104,       1'b1,32'h8C01_0004, 32'h104,       1'b1,1'b0});
      vecs.push_back('{1'b0,1'b0,32'h0,         1'b0,1'b1,32'h8,         32'h8,         1'b1,32'h0,         32'h104,       1'b0,1'b0});
      vecs.push_back('{1'b0,1'b1,32'hFFFF_FFFF, 1'b0,1'b0,32'h0,         32'h8,         1'b0,32'hFFFF_FFFF, 32'hC,         1'b1,1'b1});
      vecs.push_back('{1'b0,1'b1,32'h0000_0001, 1'b0,1'b0,32'h0,         32'h8,         1'b0,32'h0,         32'hC,         1'b0,1'b1});
      vecs.push_back('{1'b0,1'b0,32'h0,         1'b1,1'b0,32'h0,         32'h8,         1'b0,32'h0,         32'hC,         1'b0,1'b1});
      vecs.push_back('{1'b0,1'b0,32'h0,         1'b0,1'b1,32'h40,        32'h40,        1'b1,32'h0,         32'hC,         1'b0,1'b0});
      vecs.push_back('{1'b0,1'b1,32'h2000_0000, 1'b0,1'b0,32'h0,         32'h44,        1'b1,32'h2000_0000, 32'h44,        1'b1,1'b0});
      vecs.push_back('{1'b0,1'b1,32'hFC00_0000, 1'b0,1'b1,32'h200,       32'h200,       1'b1,32'h0,         32'h44,        1'b0,1'b0});
      vecs.push_back('{1'b0,1'b0,32'h0,         1'b0,1'b1,32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1,32'h0,         32'h44,        1'b0,1'b0});
      vecs.push_back('{1'b0,1'b1,32'h0000_0011, 1'b0,1'b0,32'h0,         32'h0,         1'b1,32'h0000_0011, 32'h0,         1'b1,1'b0});
      vecs.push_back('{1'b0,1'b1,32'h0000_0022, 1'b0,1'b0,32'h0,         32'h4,         1'b1,32'h0000_0022, 32'h4,         1'b1,1'b0});
      vecs.push_back('{1'b0,1'b0,32'h0,         1'b0,1'b0,32'h0,         32'h4,         1'b1,32'h0,         32'h4,         1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,32'h3333_3333, 1'b0,1'b0,32'h0,         32'h0,         1'b1,32'h0,         32'h0,         1'b0,1'b0});

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].ihit, vecs[i].load, vecs[i].stall, vecs[i].flush, vecs[i].rpc);
         chk("imemaddr",  i, imemaddr,         vecs[i].e_addr);
         chk("imemREN",   i, {31'd0, imemREN}, {31'd0, vecs[i].e_ren});
         chk("instr_out", i, instr_out,        vecs[i].e_instr);
         chk("npc_out",   i, npc_out,          vecs[i].e_npc);
         chk("valid_out", i, {31'd0, valid_out}, {31'd0, vecs[i].e_valid});
         chk("halted",    i, {31'd0, halted},  {31'd0, vecs[i].e_halt});
      end

      // Back-to-back hits then misses from a fresh reset.
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b1, 32'h0000_1000 + k, 1'b0, 1'b0, 32'h0);
         chk("seq_addr",  k, imemaddr,  32'(4 * (k + 1)));
         chk("seq_instr", k, instr_out, 32'h0000_1000 + k);
      end
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
         chk("miss_addr", k, imemaddr, 32'hC);
         chk("miss_npc",  k, npc_out,  32'hC);
      end
`ifdef FETCH_STATS_EN
      chk("fetch_count", 0, fetch_count, 32'd3);
      chk("stall_count", 0, stall_count, 32'd2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
